// File: rtl/atto_pkg.sv
// Shared opcode encoding, widths and address map for the atto SoC.
// Instruction word layout is {opcode[3:0], operand[7:0]}.
package atto_pkg;
    localparam int INSTR_W = 12;
    localparam int DATA_W  = 8;

    localparam logic [7:0] LED_ADDR = 8'hFF;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADDI = 4'h2;
    localparam logic [3:0] OP_LD   = 4'h3;
    localparam logic [3:0] OP_ST   = 4'h4;
    localparam logic [3:0] OP_JMP  = 4'h5;
    localparam logic [3:0] OP_JNZ  = 4'h6;

    function automatic logic [INSTR_W-1:0] mk_instr(input logic [3:0] op, input logic [7:0] k);
        return {op, k};
    endfunction
endpackage

// File: rtl/atto_cpu.sv
// 8-bit accumulator CPU: one instruction retires per clock, no pipeline, no stalls.
// Memory is accessed combinationally through o_addr/i_rdata; stores commit on the next edge.
module atto_cpu
    import atto_pkg::*;
(
    input  logic               clk,
    input  logic               i_rst,
    input  logic [INSTR_W-1:0] i_instr,
    input  logic [DATA_W-1:0]  i_rdata,
    output logic [7:0]         o_pc,
    output logic [7:0]         o_addr,
    output logic [DATA_W-1:0]  o_wdata,
    output logic               o_we
);
    logic [7:0]        r_pc;
    logic [DATA_W-1:0] r_acc;
    logic              r_z;

    logic [3:0]        w_op;
    logic [7:0]        w_k;
    logic [DATA_W-1:0] w_sum;

    assign w_op  = i_instr[INSTR_W-1:8];
    assign w_k   = i_instr[7:0];
    assign w_sum = r_acc + w_k;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_pc  <= 8'h00;
            r_acc <= '0;
            r_z   <= 1'b0;
        end else begin
            r_pc <= r_pc + 8'd1;
            case (w_op)
                OP_LDI: begin
                    r_acc <= w_k;
                    r_z   <= (w_k == 8'h00);
                end
                OP_ADDI: begin
                    r_acc <= w_sum;
                    r_z   <= (w_sum == 8'h00);
                end
                OP_LD: begin
                    r_acc <= i_rdata;
                    r_z   <= (i_rdata == 8'h00);
                end
                OP_JMP: r_pc <= w_k;
                OP_JNZ: if (!r_z) r_pc <= w_k;
                default: ;
            endcase
        end
    end

    // Stores are suppressed while in reset so reset dominates memory too.
    assign o_pc    = r_pc;
    assign o_addr  = w_k;
    assign o_wdata = r_acc;
    assign o_we    = (w_op == OP_ST) && !i_rst;
endmodule

// File: rtl/atto_soc.sv
// Demo SoC: CPU + fixed counter firmware ROM + 255-byte RAM + LED register at 0xFF.
// LED updates once per 6 + 2*DELAY cycles; free-running, no flow control.
module atto_soc
    import atto_pkg::*;
#(
    parameter int DELAY = 250
) (
    input  logic       clk,
    input  logic       reset,
    output logic [7:0] led
);
    localparam logic [7:0] DELAY_K = DELAY[7:0];

    logic [DATA_W-1:0] r_ram [0:254];
    logic [7:0]        r_led;

    logic [7:0]         w_pc;
    logic [7:0]         w_addr;
    logic [DATA_W-1:0]  w_wdata;
    logic [DATA_W-1:0]  w_rdata;
    logic               w_we;
    logic [INSTR_W-1:0] w_instr;

    function automatic logic [INSTR_W-1:0] rom(input logic [7:0] a);
        case (a)
            8'd0:    rom = mk_instr(OP_LDI,  8'h00);
            8'd1:    rom = mk_instr(OP_ST,   8'h00);
            8'd2:    rom = mk_instr(OP_LD,   8'h00);
            8'd3:    rom = mk_instr(OP_ADDI, 8'h01);
            8'd4:    rom = mk_instr(OP_ST,   8'h00);
            8'd5:    rom = mk_instr(OP_ST,   LED_ADDR);
            8'd6:    rom = mk_instr(OP_LDI,  DELAY_K);
            8'd7:    rom = mk_instr(OP_ADDI, 8'hFF);
            8'd8:    rom = mk_instr(OP_JNZ,  8'h07);
            8'd9:    rom = mk_instr(OP_JMP,  8'h02);
            default: rom = mk_instr(OP_NOP,  8'h00);
        endcase
    endfunction

    assign w_instr = rom(w_pc);

    atto_cpu u_cpu (
        .clk     (clk),
        .i_rst   (reset),
        .i_instr (w_instr),
        .i_rdata (w_rdata),
        .o_pc    (w_pc),
        .o_addr  (w_addr),
        .o_wdata (w_wdata),
        .o_we    (w_we)
    );

    // 0xFF has no RAM cell behind it; the LED register shadows it.
    assign w_rdata = (w_addr == LED_ADDR) ? r_led : r_ram[w_addr];

    always_ff @(posedge clk) begin
        if (w_we && (w_addr != LED_ADDR)) r_ram[w_addr] <= w_wdata;
    end

    always_ff @(posedge clk) begin
        if (reset)                              r_led <= 8'h00;
        else if (w_we && (w_addr == LED_ADDR)) r_led <= w_wdata;
    end

    assign led = r_led;
endmodule

// File: tb/tb_atto_soc.sv
// Scoreboard bench: three SoC instances (DELAY 250/1/0) against a timing model of the firmware,
// plus a directed instruction stream through a standalone CPU.
module tb_atto_soc;
    typedef struct {
        int         stamp;
        logic [7:0] val;
    } ev_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] led250, led1, led0;
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    bit         mon_en = 1'b0;
    logic [7:0] prev0 = 8'h00, prev1 = 8'h00, prev2 = 8'h00;
    ev_t        q0[$], q1[$], q2[$];
    int         dly[3] = '{250, 1, 0};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    atto_soc #(.DELAY(250)) u_d250 (.clk(clk), .reset(reset), .led(led250));
    atto_soc #(.DELAY(1))   u_d1   (.clk(clk), .reset(reset), .led(led1));
    atto_soc #(.DELAY(0))   u_d0   (.clk(clk), .reset(reset), .led(led0));

    // Standalone CPU with a bench-owned program and LED register.
    logic        cpu_rst = 1'b1;
    logic [11:0] prog [256];
    logic [7:0]  cpu_pc, cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_we;
    logic [7:0]  cpu_led = 8'h00;
    logic [11:0] cpu_instr;

    assign cpu_instr = prog[cpu_pc];
    assign cpu_rdata = (cpu_addr == 8'hFF) ? cpu_led : 8'h00;
    always @(posedge clk) if (cpu_we && cpu_addr == 8'hFF) cpu_led <= cpu_wdata;

    atto_cpu u_cpu (
        .clk     (clk),
        .i_rst   (cpu_rst),
        .i_instr (cpu_instr),
        .i_rdata (cpu_rdata),
        .o_pc    (cpu_pc),
        .o_addr  (cpu_addr),
        .o_wdata (cpu_wdata),
        .o_we    (cpu_we)
    );

    task automatic chk8(input string nm, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic push_ev(input int idx, input int stamp, input logic [7:0] v);
        ev_t e;
        e.stamp = stamp;
        e.val   = v;
        case (idx)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    // Firmware model: first LED write 6 edges after release, then one per 6+2*D cycles
    // (D=0 loops 256 times). A reset edge forces the LED to zero.
    task automatic plan_phase(input int idx, input int rel, input int stop, input bit rst_at_stop);
        int p;
        int last;
        p = 6 + 2 * ((dly[idx] == 0) ? 256 : dly[idx]);
        last = 0;
        for (int k = 0; rel + 6 + k * p < stop; k++) begin
            last = (k + 1) % 256;
            push_ev(idx, rel + 6 + k * p, 8'(last));
        end
        if (rst_at_stop && last != 0) push_ev(idx, stop, 8'h00);
    endtask

    task automatic check_ev(input int idx, input int stamp, input logic [7:0] v);
        ev_t e;
        bit  have;
        have = 1'b0;
        case (idx)
            0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        checks++;
        if (!have) begin
            failures++;
            $display("FAIL led_d%0d unexpected change to %02h at cycle %0d", dly[idx], v, stamp);
        end else if (e.stamp != stamp || e.val !== v) begin
            failures++;
            $display("FAIL led_d%0d change: got %02h at cycle %0d, expected %02h at cycle %0d",
                     dly[idx], v, stamp, e.val, e.stamp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (led250 !== prev0) begin check_ev(0, cyc, led250); prev0 = led250; end
            if (led1   !== prev1) begin check_ev(1, cyc, led1);   prev1 = led1;   end
            if (led0   !== prev2) begin check_ev(2, cyc, led0);   prev2 = led2_val(led0); end
        end
    end

    function automatic logic [7:0] led2_val(input logic [7:0] v);
        return v;
    endfunction

    // CPU unit test: LD of LED, ADDI wrap/Z, unknown opcode as NOP, PC wrap.
    logic [7:0] exp_pc [14] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h06, 8'h07,
                               8'h08, 8'h09, 8'h0A, 8'hFD, 8'hFE, 8'hFF, 8'h00};
    logic [7:0] exp_a  [14] = '{8'h00, 8'h5A, 8'h5A, 8'h00, 8'h5A, 8'h5A, 8'hFF,
                               8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    bit cpu_done = 1'b0;

    initial begin
        for (int i = 0; i < 256; i++) prog[i] = 12'h000;
        prog[0]  = 12'h15A;  // LDI 5A
        prog[1]  = 12'h4FF;  // ST  FF
        prog[2]  = 12'h100;  // LDI 00
        prog[3]  = 12'h3FF;  // LD  FF
        prog[4]  = 12'h606;  // JNZ 06 (taken, Z=0)
        prog[5]  = 12'h111;
        prog[6]  = 12'h1FF;  // LDI FF
        prog[7]  = 12'h201;  // ADDI 01 -> 00, Z=1
        prog[8]  = 12'h640;  // JNZ 40 (not taken)
        prog[9]  = 12'hA33;  // opcode A
        prog[10] = 12'h5FD;  // JMP FD
        repeat (3) @(negedge clk);
        chk8("cpu_reset_pc", cpu_pc, exp_pc[0]);
        chk8("cpu_reset_a", cpu_wdata, exp_a[0]);
        cpu_rst = 1'b0;
        for (int i = 1; i < 14; i++) begin
            @(negedge clk);
            chk8($sformatf("cpu_pc_step%0d", i), cpu_pc, exp_pc[i]);
            chk8($sformatf("cpu_a_step%0d", i), cpu_wdata, exp_a[i]);
        end
        cpu_done = 1'b1;
    end

    initial begin
        int r1, m, hold, rel2, stop2;
        @(negedge clk);
        mon_en = 1'b1;
        r1 = 3 + $urandom_range(0, 3);
        while (cyc < r1) @(negedge clk);
        chk8("reset_led_d250", led250, 8'h00);
        chk8("reset_led_d1", led1, 8'h00);
        chk8("reset_led_d0", led0, 8'h00);
        // Mid-run reset lands inside the delay loop that follows the 0x05 write.
        m = r1 + 6 + 4 * 506 + $urandom_range(3, 500);
        for (int i = 0; i < 3; i++) plan_phase(i, r1, m, 1'b1);
        reset = 1'b0;

        while (cyc < m - 1) @(negedge clk);
        chk8("pre_reset_led_d250", led250, 8'h05);
        reset = 1'b1;
        hold = 1 + $urandom_range(0, 2);
        @(negedge clk);
        chk8("midrun_reset_led_d250", led250, 8'h00);
        while (cyc < m + hold - 1) @(negedge clk);
        rel2  = cyc;
        stop2 = rel2 + 2200;
        for (int i = 0; i < 3; i++) plan_phase(i, rel2, stop2 + 1, 1'b0);
        reset = 1'b0;

        while (cyc < stop2 + 1) @(negedge clk);
        while (!cpu_done && cyc < stop2 + 100) @(negedge clk);
        checks++;
        if (!cpu_done) begin
            failures++;
            $display("FAIL cpu_test_timeout: got not-done expected done");
        end
        checks++;
        if (q0.size() != 0) begin failures++; $display("FAIL led_d250 pending: got %0d expected 0", q0.size()); end
        checks++;
        if (q1.size() != 0) begin failures++; $display("FAIL led_d1 pending: got %0d expected 0", q1.size()); end
        checks++;
        if (q2.size() != 0) begin failures++; $display("FAIL led_d0 pending: got %0d expected 0", q2.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
